spi_slave_shifter: RTL and testbench

//  Target-side SPI serial engine: the receiving end of the master SCK/data path.

---
 rtl/spi_slave_shifter.sv | 189 ++++++++++++++++++
 tb/tb_spi_slave_shifter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_shifter.sv
// SPI target-side serial engine: oversamples SCK/CS/MOSI in the local clock domain,
// deserializes MOSI into words and serializes a single-entry buffered TX word onto MISO.
module spi_slave_shifter #(
  parameter int unsigned       PHASE  = 0,
  parameter int unsigned       ACTIVE = 0,
  parameter int unsigned       DSIZE  = 8,
  parameter logic [DSIZE-1:0]  FILL   = '0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic [DSIZE-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_overrun,
  input  logic             rx_ack,
  input  logic [DSIZE-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_abort
);

  localparam int unsigned     CntW    = (DSIZE > 2) ? $clog2(DSIZE) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DSIZE - 1);
  localparam logic            IdleLvl = (ACTIVE != 0);

  typedef enum logic {StIdle, StSelect} state_e;

  state_e state_q, state_d;

  logic sck_s1_q, sck_s2_q, sck_d_q;
  logic cs_s1_q, cs_s2_q;
  logic mosi_s1_q, mosi_s2_q;

  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DSIZE-1:0] shift_rx_q, shift_rx_d;
  logic [DSIZE-1:0] shift_tx_q, shift_tx_d;
  logic [DSIZE-1:0] rx_data_q, rx_data_d;
  logic [DSIZE-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic             oe_q, oe_d;
  logic             rx_valid_q, rx_valid_d;
  logic             pending_q, pending_d;
  logic             underrun_q, underrun_d;
  logic             abort_q, abort_d;

  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic load;

  // Two-flop synchronizers; sck_d_q gives the previous synced SCK level for edge detection.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sck_s1_q  <= IdleLvl;
      sck_s2_q  <= IdleLvl;
      sck_d_q   <= IdleLvl;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sck_s1_q  <= spi_sck;
      sck_s2_q  <= sck_s1_q;
      sck_d_q   <= sck_s2_q;
      cs_s1_q   <= spi_cs_n;
      cs_s2_q   <= cs_s1_q;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sck_edge    = (sck_s2_q != sck_d_q) && !cs_s2_q;
  assign lead_edge   = sck_edge && (sck_s2_q != IdleLvl);
  assign trail_edge  = sck_edge && (sck_s2_q == IdleLvl);
  assign sample_edge = (PHASE == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (PHASE == 0) ? trail_edge : lead_edge;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_rx_d = shift_rx_q;
    shift_tx_d = shift_tx_q;
    rx_data_d  = rx_data_q;
    oe_d       = oe_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      StIdle: begin
        oe_d       = 1'b0;
        shift_tx_d = '0;
        bit_cnt_d  = '0;
        if (!cs_s2_q) begin
          state_d = StSelect;
          oe_d    = 1'b1;
          load    = (PHASE == 0);
        end
      end
      StSelect: begin
        if (cs_s2_q) begin
          state_d    = StIdle;
          oe_d       = 1'b0;
          shift_tx_d = '0;
          bit_cnt_d  = '0;
          abort_d    = (bit_cnt_q != '0);
        end else if (sample_edge) begin
          shift_rx_d = {shift_rx_q[DSIZE-2:0], mosi_s2_q};
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d  = '0;
            rx_data_d  = shift_rx_d;
            rx_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else if (shift_edge) begin
          // A zero bit count on a shift edge marks a word boundary in both phases.
          if (bit_cnt_q == '0) begin
            load = 1'b1;
          end else begin
            shift_tx_d = {shift_tx_q[DSIZE-2:0], 1'b0};
          end
        end
      end
    endcase

    if (load) begin
      shift_tx_d = buf_full_q ? buf_q : FILL;
      underrun_d = !buf_full_q;
    end

    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (load) begin
      buf_full_d = 1'b0;
    end
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    // Ack clears the old pending before this rx_valid re-arms it.
    pending_d = (pending_q && !rx_ack) || rx_valid_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_rx_q <= '0;
      shift_tx_q <= '0;
      rx_data_q  <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      oe_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_rx_q <= shift_rx_d;
      shift_tx_q <= shift_tx_d;
      rx_data_q  <= rx_data_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      oe_q       <= oe_d;
      rx_valid_q <= rx_valid_d;
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  assign spi_miso    = oe_q & shift_tx_q[DSIZE-1];
  assign spi_miso_oe = oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_valid_q & pending_q & ~rx_ack;
  assign tx_ready    = ~buf_full_q;
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: a mode-0 and a mode-3 instance driven by a bit-banged master,
// with received words checked through per-instance scoreboards.
module tb_spi_slave_shifter;

  localparam int Half = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sck0, cs0_n, mosi0, miso0, oe0;
  logic       sck3, cs3_n, mosi3, miso3, oe3;
  logic [7:0] rx_data0, rx_data3, tx_data0, tx_data3;
  logic       rx_valid0, rx_valid3, ovr0, ovr3, ack0, ack3;
  logic       tx_valid0, tx_valid3, rdy0, rdy3, und0, und3, abort0, abort3;
  logic       ack_force, ack_follow;

  assign ack0 = ack_force | (ack_follow & rx_valid0);

  spi_slave_shifter #(.PHASE(0), .ACTIVE(0), .DSIZE(8), .FILL(8'h00)) u_m0 (
    .clock(clk), .rst_n(rst_n), .spi_sck(sck0), .spi_cs_n(cs0_n), .spi_mosi(mosi0),
    .spi_miso(miso0), .spi_miso_oe(oe0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_overrun(ovr0), .rx_ack(ack0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(rdy0), .tx_underrun(und0), .frame_abort(abort0)
  );

  spi_slave_shifter #(.PHASE(1), .ACTIVE(1), .DSIZE(8), .FILL(8'h00)) u_m3 (
    .clock(clk), .rst_n(rst_n), .spi_sck(sck3), .spi_cs_n(cs3_n), .spi_mosi(mosi3),
    .spi_miso(miso3), .spi_miso_oe(oe3), .rx_data(rx_data3), .rx_valid(rx_valid3),
    .rx_overrun(ovr3), .rx_ack(ack3), .tx_data(tx_data3), .tx_valid(tx_valid3),
    .tx_ready(rdy3), .tx_underrun(und3), .frame_abort(abort3)
  );

  int n_checks = 0, n_pass = 0;
  int sb_checks = 0, sb_pass = 0;
  int cnt_valid0 = 0, cnt_valid3 = 0, cnt_und0 = 0, cnt_und3 = 0;
  int cnt_ovr0 = 0, cnt_abort0 = 0, cnt_abort3 = 0;
  int latency0 = 0;
  time last_rise0 = 0;
  logic [7:0] exp_rx0[$];
  logic [7:0] exp_rx3[$];
  logic [7:0] e0, e3;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] rx_exp;
    logic [7:0] miso_exp;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard side: pop the expected word whenever a DUT reports one.
  always @(negedge clk) begin
    if (rx_valid0) begin
      cnt_valid0++;
      latency0 = int'(($time - last_rise0) / 10);
      sb_checks++;
      if (exp_rx0.size() == 0) begin
        $display("FAIL sb_rx0: unexpected word 0x%0h, expected none", rx_data0);
      end else begin
        e0 = exp_rx0.pop_front();
        if (rx_data0 === e0) sb_pass++;
        else $display("FAIL sb_rx0: got 0x%0h, expected 0x%0h", rx_data0, e0);
      end
    end
    if (rx_valid3) begin
      cnt_valid3++;
      sb_checks++;
      if (exp_rx3.size() == 0) begin
        $display("FAIL sb_rx3: unexpected word 0x%0h, expected none", rx_data3);
      end else begin
        e3 = exp_rx3.pop_front();
        if (rx_data3 === e3) sb_pass++;
        else $display("FAIL sb_rx3: got 0x%0h, expected 0x%0h", rx_data3, e3);
      end
    end
    if (und0) cnt_und0++;
    if (und3) cnt_und3++;
    if (ovr0) cnt_ovr0++;
    if (abort0) cnt_abort0++;
    if (abort3) cnt_abort3++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_tx(input bit m3, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (m3) begin tx_data3 = d; tx_valid3 = 1'b1; end
    else begin tx_data0 = d; tx_valid0 = 1'b1; end
    for (int i = 0; i < 400; i++) begin
      if (m3 ? rdy3 : rdy0) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (m3) tx_valid3 = 1'b0;
    else tx_valid0 = 1'b0;
    check("tx_accept", 32'(ok), 32'd1);
  endtask

  task automatic frame_start(input bit m3);
    @(negedge clk);
    if (m3) cs3_n = 1'b0;
    else cs0_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end(input bit m3);
    repeat (Half) @(negedge clk);
    if (m3) cs3_n = 1'b1;
    else cs0_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Sends the top nbits of w MSB first; got collects MISO at the master's sample edges.
  task automatic spi_bits(input bit m3, input logic [7:0] w, input int nbits,
                          output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!m3) begin
        mosi0 = w[7-i];
        repeat (Half) @(negedge clk);
        got = {got[6:0], miso0};
        sck0 = 1'b1;
        last_rise0 = $time;
        repeat (Half) @(negedge clk);
        sck0 = 1'b0;
      end else begin
        sck3  = 1'b0;
        mosi3 = w[7-i];
        repeat (Half) @(negedge clk);
        got = {got[6:0], miso3};
        sck3 = 1'b1;
        repeat (Half) @(negedge clk);
      end
    end
  endtask

  logic [7:0] got;
  logic [7:0] t2_mosi[3];
  logic [7:0] t2_tx[3];
  logic [7:0] t2_got[3];
  int v0, u0, u3, o0, a0, a3;

  initial begin
    vecs[0] = '{tx: 8'hA5, mosi: 8'h3C, rx_exp: 8'h3C, miso_exp: 8'hA5};
    vecs[1] = '{tx: 8'h5A, mosi: 8'hC3, rx_exp: 8'hC3, miso_exp: 8'h5A};
    vecs[2] = '{tx: 8'hFF, mosi: 8'h00, rx_exp: 8'h00, miso_exp: 8'hFF};
    vecs[3] = '{tx: 8'h00, mosi: 8'hFF, rx_exp: 8'hFF, miso_exp: 8'h00};
    vecs[4] = '{tx: 8'h81, mosi: 8'h7E, rx_exp: 8'h7E, miso_exp: 8'h81};
    t2_mosi = '{8'h01, 8'h80, 8'hFF};
    t2_tx   = '{8'h11, 8'h22, 8'h33};

    rst_n = 1'b0;
    sck0 = 1'b0; cs0_n = 1'b1; mosi0 = 1'b0;
    sck3 = 1'b1; cs3_n = 1'b1; mosi3 = 1'b0;
    tx_data0 = '0; tx_valid0 = 1'b0; tx_data3 = '0; tx_valid3 = 1'b0;
    ack_force = 1'b1; ack_follow = 1'b0; ack3 = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_miso", 32'(miso0), 32'd0);
    check("rst_oe", 32'(oe0), 32'd0);
    check("rst_rx_data", 32'(rx_data0), 32'd0);
    check("rst_rx_valid", 32'(rx_valid0), 32'd0);
    check("rst_tx_ready", 32'(rdy0), 32'd1);
    check("rst_underrun", 32'(und0), 32'd0);
    check("rst_abort", 32'(abort0), 32'd0);
    check("rst_oe3", 32'(oe3), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Mode 0 single-word frames.
    for (int k = 0; k < 5; k++) begin
      v0 = cnt_valid0;
      a0 = cnt_abort0;
      push_tx(1'b0, vecs[k].tx);
      exp_rx0.push_back(vecs[k].rx_exp);
      frame_start(1'b0);
      check("oe_in_frame", 32'(oe0), 32'd1);
      spi_bits(1'b0, vecs[k].mosi, 8, got);
      frame_end(1'b0);
      check("miso_word", 32'(got), 32'(vecs[k].miso_exp));
      check("rx_latency", 32'(latency0), 32'd3);
      check("rx_valid_count", 32'(cnt_valid0 - v0), 32'd1);
      check("no_abort", 32'(cnt_abort0 - a0), 32'd0);
    end
    check("oe_after_frame", 32'(oe0), 32'd0);
    check("miso_after_frame", 32'(miso0), 32'd0);

    // Mode 3 back-to-back words with the TX buffer refilled each word.
    v0 = cnt_valid3;
    u3 = cnt_und3;
    push_tx(1'b1, t2_tx[0]);
    for (int k = 0; k < 3; k++) exp_rx3.push_back(t2_mosi[k]);
    fork
      begin
        frame_start(1'b1);
        for (int k = 0; k < 3; k++) begin
          spi_bits(1'b1, t2_mosi[k], 8, got);
          t2_got[k] = got;
        end
        frame_end(1'b1);
      end
      begin
        for (int k = 1; k < 3; k++) push_tx(1'b1, t2_tx[k]);
      end
    join
    for (int k = 0; k < 3; k++) check("m3_miso_word", 32'(t2_got[k]), 32'(t2_tx[k]));
    check("m3_rx_valid_count", 32'(cnt_valid3 - v0), 32'd3);
    check("m3_no_underrun", 32'(cnt_und3 - u3), 32'd0);

    // Empty buffer: FILL goes out and underrun pulses once.
    u3 = cnt_und3;
    exp_rx3.push_back(8'h96);
    frame_start(1'b1);
    spi_bits(1'b1, 8'h96, 8, got);
    frame_end(1'b1);
    check("fill_miso", 32'(got), 32'h00);
    check("underrun_once", 32'(cnt_und3 - u3), 32'd1);

    // Abort after 5 bits, then a clean frame.
    v0 = cnt_valid0;
    a0 = cnt_abort0;
    push_tx(1'b0, 8'hC6);
    frame_start(1'b0);
    spi_bits(1'b0, 8'hF0, 5, got);
    frame_end(1'b0);
    check("abort_pulse", 32'(cnt_abort0 - a0), 32'd1);
    check("abort_no_rx", 32'(cnt_valid0 - v0), 32'd0);
    push_tx(1'b0, 8'h3C);
    exp_rx0.push_back(8'h5A);
    frame_start(1'b0);
    spi_bits(1'b0, 8'h5A, 8, got);
    frame_end(1'b0);
    check("post_abort_miso", 32'(got), 32'h3C);
    check("post_abort_count", 32'(cnt_abort0 - a0), 32'd1);

    // Mode 3 abort: loaded word dropped, buffered word survives into the next frame.
    a3 = cnt_abort3;
    push_tx(1'b1, 8'hE7);
    frame_start(1'b1);
    spi_bits(1'b1, 8'h00, 3, got);
    push_tx(1'b1, 8'h4B);
    frame_end(1'b1);
    check("m3_abort_miso", 32'(got), 32'h07);
    check("m3_abort_pulse", 32'(cnt_abort3 - a3), 32'd1);
    check("m3_buffer_kept", 32'(rdy3), 32'd0);
    exp_rx3.push_back(8'hA9);
    frame_start(1'b1);
    spi_bits(1'b1, 8'hA9, 8, got);
    frame_end(1'b1);
    check("m3_kept_miso", 32'(got), 32'h4B);

    // Overrun handling.
    @(negedge clk);
    ack_force = 1'b0;
    o0 = cnt_ovr0;
    exp_rx0.push_back(8'h12);
    exp_rx0.push_back(8'h34);
    frame_start(1'b0);
    spi_bits(1'b0, 8'h12, 8, got);
    spi_bits(1'b0, 8'h34, 8, got);
    frame_end(1'b0);
    check("overrun_2nd", 32'(cnt_ovr0 - o0), 32'd1);
    o0 = cnt_ovr0;
    ack_follow = 1'b1;
    exp_rx0.push_back(8'h56);
    frame_start(1'b0);
    spi_bits(1'b0, 8'h56, 8, got);
    frame_end(1'b0);
    check("ack_coincident", 32'(cnt_ovr0 - o0), 32'd0);
    ack_follow = 1'b0;
    o0 = cnt_ovr0;
    exp_rx0.push_back(8'h78);
    frame_start(1'b0);
    spi_bits(1'b0, 8'h78, 8, got);
    frame_end(1'b0);
    check("overrun_rearmed", 32'(cnt_ovr0 - o0), 32'd1);
    ack_force = 1'b1;

    // Reset mid-word, then SCK with CS high.
    push_tx(1'b0, 8'h99);
    frame_start(1'b0);
    spi_bits(1'b0, 8'hFF, 4, got);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_oe", 32'(oe0), 32'd0);
    check("midrst_miso", 32'(miso0), 32'd0);
    check("midrst_rx_data", 32'(rx_data0), 32'd0);
    check("midrst_tx_ready", 32'(rdy0), 32'd1);
    cs0_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    v0 = cnt_valid0;
    a0 = cnt_abort0;
    u0 = cnt_und0;
    for (int k = 0; k < 16; k++) begin
      sck0 = ~sck0;
      repeat (Half) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("idle_no_rx", 32'(cnt_valid0 - v0), 32'd0);
    check("idle_no_abort", 32'(cnt_abort0 - a0), 32'd0);
    check("idle_no_underrun", 32'(cnt_und0 - u0), 32'd0);
    check("idle_oe", 32'(oe0), 32'd0);
    check("sb_empty0", 32'(exp_rx0.size()), 32'd0);
    check("sb_empty3", 32'(exp_rx3.size()), 32'd0);

    n_checks += sb_checks;
    n_pass   += sb_pass;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
